// File: rtl/s3_inc8_arb.sv
`default_nettype none
// ============================================================================
// Module   : s3_inc8_arb
// Purpose  : Round-robin arbiter that shares a single s3_inc8 incrementer
//            among NREQ requesters. One operand is accepted at a time,
//            incremented (mod 256) and returned with its requester id.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk        in   1        clock
//   rst        in   1        synchronous active-high reset
//   req_valid  in   NREQ     bit i: requester i offers an operand
//   req_data   in   8*NREQ   operand i on bits [8*i+7:8*i]
//   req_ready  out  NREQ     one-hot accept pulse (combinational)
//   rsp_valid  out  1        result available
//   rsp_data   out  8        (operand + 1) mod 256
//   rsp_id     out  IDW      requester index that issued the operand
//   rsp_carry  out  1        operand was 8'hFF (result wrapped)
//   rsp_ready  in   1        consumer accepts result
// Parameters
//   NREQ       number of requesters, 2..8
//   IDW        width of rsp_id, equal to clog2(NREQ)
// ============================================================================
module s3_inc8_arb #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [8*NREQ-1:0]   req_data,
    output logic [NREQ-1:0]     req_ready,
    output logic                rsp_valid,
    output logic [7:0]          rsp_data,
    output logic [IDW-1:0]      rsp_id,
    output logic                rsp_carry,
    input  logic                rsp_ready
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    // Last-grant pointer resets to the top index so requester 0 wins first.
    localparam logic [IDW-1:0] PTR_RST = IDW'(NREQ - 1);
    localparam logic [IDW:0]   NREQ_W  = (IDW + 1)'(NREQ);

    logic [1:0]     state_q, state_d;
    logic [7:0]     operand_q, operand_d;
    logic [IDW-1:0] id_q, id_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic           rsp_valid_q, rsp_valid_d;
    logic [7:0]     rsp_data_q, rsp_data_d;
    logic [IDW-1:0] rsp_id_q, rsp_id_d;
    logic           rsp_carry_q, rsp_carry_d;

    logic           win_found;
    logic [IDW-1:0] win_id;
    logic [IDW:0]   cand;
    logic [7:0]     inc_x;

    // ------------------------------------------------------------------
    // Round-robin winner search: first valid requester starting at ptr+1,
    // wrapping modulo NREQ. cand is one bit wider than the pointer so the
    // sum ptr+k never overflows before the wrap correction.
    // ------------------------------------------------------------------
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        cand      = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = {1'b0, ptr_q} + (IDW + 1)'(k);
            if (cand >= NREQ_W) begin
                cand = cand - NREQ_W;
            end
            if (!win_found && req_valid[cand[IDW-1:0]]) begin
                win_found = 1'b1;
                win_id    = cand[IDW-1:0];
            end
        end
    end

    // ------------------------------------------------------------------
    // The single shared s3_inc8 incrementer; its only input is the
    // operand register, so it is time-multiplexed across requesters.
    // ------------------------------------------------------------------
    assign inc_x = operand_q + 8'd1;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (win_found) state_d = ST_EXEC;
            ST_EXEC: state_d = ST_RESP;
            ST_RESP: if (rsp_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs. req_ready is purely combinational and is held low
    // while reset is asserted so no operand is taken during reset.
    // ------------------------------------------------------------------
    always_comb begin
        req_ready = '0;
        if (!rst && (state_q == ST_IDLE) && win_found) begin
            req_ready[win_id] = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Datapath next values
    // ------------------------------------------------------------------
    always_comb begin
        operand_d   = operand_q;
        id_d        = id_q;
        ptr_d       = ptr_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_id_d    = rsp_id_q;
        rsp_carry_d = rsp_carry_q;
        case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    operand_d = req_data[{win_id, 3'b000} +: 8];
                    id_d      = win_id;
                    ptr_d     = win_id;
                end
            end
            ST_EXEC: begin
                rsp_data_d  = inc_x;
                rsp_id_d    = id_q;
                rsp_carry_d = (operand_q == 8'hFF);
                rsp_valid_d = 1'b1;
            end
            ST_RESP: begin
                // Only valid drops; data/id/carry keep their last value.
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                end
            end
            default: begin
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            operand_q   <= 8'h00;
            id_q        <= '0;
            ptr_q       <= PTR_RST;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 8'h00;
            rsp_id_q    <= '0;
            rsp_carry_q <= 1'b0;
        end else begin
            operand_q   <= operand_d;
            id_q        <= id_d;
            ptr_q       <= ptr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_id_q    <= rsp_id_d;
            rsp_carry_q <= rsp_carry_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_carry = rsp_carry_q;

endmodule
`default_nettype wire
